uart_tx_ctrl: RTL and testbench

//   Transmit-side controller for the UART TX byte FIFO. Pops one word at a time from the FIFO.

---
 rtl/uart_tx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one word from the TX FIFO and serialises it as start, data LSB-first, optional parity, stop.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_rden,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_SIZE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_cfg
    $error("uart_tx_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign bit_end   = (div_q == DIV_LAST);
  assign fifo_rden = (state_q == S_POP);
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_done   = (state_q == S_STOP) && bit_end && (bit_cnt_q == STOP_LAST);
  assign tx        = tx_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: if (tx_enable && !fifo_empty) state_d = S_POP;
      S_POP:  state_d = S_LOAD;
      S_LOAD: begin
        shreg_d   = fifo_data;
        div_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          div_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_STOP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line changes together with the state
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the whole word at load time since the shift register is consumed by DATA
  always_ff @(posedge clock) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (state_q == S_LOAD) begin
      par_q <= (^fifo_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised self-checking bench for uart_tx_ctrl: a FIFO model feeds the DUT and a
// frame-level reference computes the expected tx waveform from each popped word.
module tb_uart_tx_ctrl;

  localparam int CPB  = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = CPB * (1 + 8 + P + 1);

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rden;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [256];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int rden_cnt  = 0;
  int rden_bad  = 0;
  int done_cnt  = 0;

  uart_tx_ctrl #(
    .DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(PODD)
  ) dut (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rden(fifo_rden), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  // FIFO with registered read data, valid the cycle after the pop
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clock) begin
    if (fifo_rden === 1'b1) begin
      rden_cnt <= rden_cnt + 1;
      if (fifo_empty) rden_bad <= rden_bad + 1;
      else begin
        fifo_data <= mem[rd_ptr % 256];
        rd_ptr    <= rd_ptr + 1;
      end
    end
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Expected line level in frame cycle c (0 = first start-bit cycle)
  function automatic logic exp_tx(input logic [7:0] d, input int c);
    int b;
    b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P == 1 && b == 9) return (^d) ^ 1'(PODD);
    return 1'b1;
  endfunction

  task automatic expect_frame(input logic [7:0] d, input string tag, input int drop_at,
                              output int waited);
    logic exp_done;
    waited = 0;
    for (int w = 1; w <= 20; w++) begin
      @(negedge clock);
      if (fifo_rden === 1'b1) begin
        waited = w;
        break;
      end
    end
    vectors++;
    if (waited == 0) begin
      miscompares++;
      $display("FAIL %s pop: fifo_rden not seen within 20 cycles, required a pulse", tag);
      return;
    end
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s pop_state: tx=%b busy=%b, required tx=1 busy=1", tag, tx, tx_busy);
    end
    @(negedge clock);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b1 || fifo_rden !== 1'b0) begin
      miscompares++;
      $display("FAIL %s load: tx=%b busy=%b rden=%b, required 1 1 0", tag, tx, tx_busy, fifo_rden);
    end
    for (int c = 0; c < FL; c++) begin
      @(negedge clock);
      exp_done = (c == FL - 1);
      vectors++;
      if (tx !== exp_tx(d, c)) begin
        miscompares++;
        $display("FAIL %s tx d=%h cycle %0d: got %b, required %b", tag, d, c, tx, exp_tx(d, c));
      end
      vectors++;
      if (tx_done !== exp_done) begin
        miscompares++;
        $display("FAIL %s tx_done cycle %0d: got %b, required %b", tag, c, tx_done, exp_done);
      end
      vectors++;
      if (tx_busy !== 1'b1 || fifo_rden !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy/rden cycle %0d: got %b/%b, required 1/0", tag, c, tx_busy, fifo_rden);
      end
      if (c == drop_at) tx_enable = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_enable = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, required 1", tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    vectors++;
    if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, required 0", tx_done); end
    vectors++;
    if (fifo_rden !== 1'b0) begin miscompares++; $display("FAIL reset_rden: got %b, required 0", fifo_rden); end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int w;
    push(8'hA5);
    tx_enable = 1'b1;
    expect_frame(8'hA5, "single", -1, w);
    @(negedge clock);
    vectors++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL single_after: busy=%b tx=%b, required 0 1", tx_busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    int w, r0, d0;
    tx_enable = 1'b0;
    @(negedge clock);
    r0 = rden_cnt;
    d0 = done_cnt;
    push(8'h00);
    push(8'hFF);
    tx_enable = 1'b1;
    expect_frame(8'h00, "b2b0", -1, w);
    @(negedge clock);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rden !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: tx=%b busy=%b rden=%b, required 1 0 0", tx, tx_busy, fifo_rden);
    end
    expect_frame(8'hFF, "b2b1", -1, w);
    vectors++;
    if (w != 1) begin miscompares++; $display("FAIL b2b_gap: pop after %0d cycles, required 1", w); end
    repeat (10) @(negedge clock);
    vectors++;
    if (rden_cnt - r0 != 2) begin miscompares++; $display("FAIL b2b_pops: got %0d, required 2", rden_cnt - r0); end
    vectors++;
    if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_dones: got %0d, required 2", done_cnt - d0); end
  endtask

  task automatic test_random_stream();
    logic [7:0] words [8];
    int w, r0;
    tx_enable = 1'b0;
    @(negedge clock);
    r0 = rden_cnt;
    words[0] = 8'h07;
    for (int i = 1; i < 8; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) push(words[i]);
    tx_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_frame(words[i], "rand", -1, w);
      if (i > 0) begin
        vectors++;
        if (w != 1) begin miscompares++; $display("FAIL rand_gap %0d: pop after %0d, required 1", i, w); end
      end
      @(negedge clock);
      vectors++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_idle %0d: tx=%b busy=%b, required 1 0", i, tx, tx_busy);
      end
    end
    vectors++;
    if (rden_cnt - r0 != 8) begin miscompares++; $display("FAIL rand_pops: got %0d, required 8", rden_cnt - r0); end
  endtask

  task automatic test_disabled();
    int w, bad;
    tx_enable = 1'b0;
    push(8'h3C);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      vectors++;
      if (fifo_rden !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
        miscompares++;
        if (bad++ < 3)
          $display("FAIL disabled cycle %0d: rden=%b tx=%b busy=%b, required 0 1 0", i, fifo_rden, tx, tx_busy);
      end
    end
    tx_enable = 1'b1;
    expect_frame(8'h3C, "enable", -1, w);
    vectors++;
    if (w > 2) begin miscompares++; $display("FAIL enable_latency: %0d cycles, required <= 2", w); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w1, w2;
    int w, r0, d0, seen;
    tx_enable = 1'b0;
    repeat (2) @(negedge clock);
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    r0 = rden_cnt;
    d0 = done_cnt;
    push(w1);
    push(w2);
    tx_enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clock);
      if (fifo_rden === 1'b1) seen = 1;
    end
    vectors++;
    if (seen == 0) begin miscompares++; $display("FAIL rmid_pop: no pop seen, required a pulse"); end
    @(negedge clock);
    for (int c = 0; c <= 4 * CPB + 1; c++) begin
      @(negedge clock);
      vectors++;
      if (tx !== exp_tx(w1, c)) begin
        miscompares++;
        $display("FAIL rmid_tx cycle %0d: got %b, required %b", c, tx, exp_tx(w1, c));
      end
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_rden !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_reset: tx=%b busy=%b done=%b rden=%b, required 1 0 0 0", tx, tx_busy, tx_done, fifo_rden);
    end
    reset = 1'b0;
    vectors++;
    if (rden_cnt - r0 != 1 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL rmid_counts: pops=%0d dones=%0d, required 1 0", rden_cnt - r0, done_cnt - d0);
    end
    expect_frame(w2, "rmid_next", -1, w);
  endtask

  task automatic test_enable_drop();
    int w, r0, d0, bad;
    logic [7:0] w2;
    tx_enable = 1'b0;
    repeat (2) @(negedge clock);
    w2 = 8'($urandom);
    r0 = rden_cnt;
    d0 = done_cnt;
    push(8'h5A);
    push(w2);
    tx_enable = 1'b1;
    expect_frame(8'h5A, "drop", 1, w);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (fifo_rden !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL drop_idle: %0d active cycles, required 0", bad); end
    vectors++;
    if (rden_cnt - r0 != 1 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL drop_counts: pops=%0d dones=%0d, required 1 1", rden_cnt - r0, done_cnt - d0);
    end
    tx_enable = 1'b1;
    expect_frame(w2, "drop_resume", -1, w);
  endtask

  initial begin
    reset = 1'b1;
    tx_enable = 1'b0;
    fifo_data = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_stream();
    test_disabled();
    test_reset_mid();
    test_enable_drop();
    repeat (5) @(negedge clock);
    vectors++;
    if (rden_bad != 0) begin miscompares++; $display("FAIL rden_empty: %0d pops while empty, required 0", rden_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
